// File: rtl/regfile_pkg.sv
// Shared types for the multi-port register file.
// Holds the dump FSM state encoding and the address-width helper.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } dump_state_e;

    function automatic int aw_f(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump engine: streams entries 0..DEPTH-1 over a valid/ready port.
// Ports: start/busy/valid/ready handshake, beat addr/data/tag out,
// arr_addr_o/arr_data_i/arr_tag_i look up the entry under the pointer.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int AW     = 5,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AW-1:0]     addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [AW-1:0]     arr_addr_o,
    input  logic [DATA_W-1:0] arr_data_i,
    input  logic [TAG_W-1:0]  arr_tag_i
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    dump_state_e     state_q;
    logic [AW-1:0]   ptr_q;
    logic            valid_q;
    logic            busy_q;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= STREAM;
                        ptr_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                STREAM: begin
                    // valid is always high here, so ready alone
                    // completes the handshake
                    if (ready_i) begin
                        if (ptr_q == LAST) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign valid_o    = valid_q;
    assign addr_o     = ptr_q;
    assign arr_addr_o = ptr_q;
    // Live array view: a write during a stall shows up on the beat
    assign data_o     = arr_data_i;
    assign tag_o      = arr_tag_i;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD comb reads, 2 prioritised writes,
// optional bypass and zero entry 0, plus a valid/ready dump stream.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 32,
    parameter int NRD     = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1,
    localparam int AW     = aw_f(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  reset_n,
    input  logic [NRD*AW-1:0]     rd_addr_i,
    output logic [NRD*DATA_W-1:0] rd_data_o,
    output logic [NRD*TAG_W-1:0]  rd_tag_o,
    input  logic                  wa_en_i,
    input  logic [AW-1:0]         wa_addr_i,
    input  logic [DATA_W-1:0]     wa_data_i,
    input  logic [TAG_W-1:0]      wa_tag_i,
    input  logic                  wb_en_i,
    input  logic [AW-1:0]         wb_addr_i,
    input  logic [DATA_W-1:0]     wb_data_i,
    input  logic [TAG_W-1:0]      wb_tag_i,
    input  logic                  dump_start_i,
    output logic                  dump_busy_o,
    output logic                  dump_valid_o,
    input  logic                  dump_ready_i,
    output logic [AW-1:0]         dump_addr_o,
    output logic [DATA_W-1:0]     dump_data_o,
    output logic [TAG_W-1:0]      dump_tag_o
);

    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [TAG_W-1:0]  mem_tag_q  [DEPTH];

    logic wa_ok;
    logic wb_ok;

    // Entry 0 is never written when hardwired, so the array
    // and the bypass both naturally yield 0/0 for it
    assign wa_ok = wa_en_i && !((ZERO_R0 != 0) && (wa_addr_i == '0));
    assign wb_ok = wb_en_i && !((ZERO_R0 != 0) && (wb_addr_i == '0));

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_tag_q[i]  <= '0;
            end
        end else begin
            if (wa_ok) begin
                mem_data_q[wa_addr_i] <= wa_data_i;
                mem_tag_q[wa_addr_i]  <= wa_tag_i;
            end
            // Later assignment wins: B overrides A on a collision
            if (wb_ok) begin
                mem_data_q[wb_addr_i] <= wb_data_i;
                mem_tag_q[wb_addr_i]  <= wb_tag_i;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]     a;
        logic [DATA_W-1:0] d;
        logic [TAG_W-1:0]  t;

        assign a = rd_addr_i[k*AW +: AW];

        always_comb begin
            d = mem_data_q[a];
            t = mem_tag_q[a];
            if (BYPASS != 0) begin
                if (wb_ok && (wb_addr_i == a)) begin
                    d = wb_data_i;
                    t = wb_tag_i;
                end else if (wa_ok && (wa_addr_i == a)) begin
                    d = wa_data_i;
                    t = wa_tag_i;
                end
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = d;
        assign rd_tag_o[k*TAG_W +: TAG_W]    = t;
    end

    logic [AW-1:0] dump_arr_addr;

    regfile_dump_fsm #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_dump (
        .clk_i      (clk_i),
        .reset_n    (reset_n),
        .start_i    (dump_start_i),
        .busy_o     (dump_busy_o),
        .valid_o    (dump_valid_o),
        .ready_i    (dump_ready_i),
        .addr_o     (dump_addr_o),
        .data_o     (dump_data_o),
        .tag_o      (dump_tag_o),
        .arr_addr_o (dump_arr_addr),
        .arr_data_i (mem_data_q[dump_arr_addr]),
        .arr_tag_i  (mem_tag_q[dump_arr_addr])
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp (bypass and no-bypass
// instances sharing stimulus), covering reads, writes and dump.
module tb_regfile_mp;

    localparam int AW = 5;

    logic        clk;
    logic        rst_n;
    logic [14:0] rd_addr;
    logic [95:0] rd_data;
    logic [11:0] rd_tag;
    logic        wa_en;
    logic [4:0]  wa_addr;
    logic [31:0] wa_data;
    logic [3:0]  wa_tag;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  wb_tag;
    logic        start;
    logic        busy;
    logic        valid;
    logic        ready;
    logic [4:0]  daddr;
    logic [31:0] ddata;
    logic [3:0]  dtag;

    logic [95:0] nb_rd_data;
    logic [11:0] nb_rd_tag;
    logic        nb_busy;
    logic        nb_valid;
    logic [4:0]  nb_daddr;
    logic [31:0] nb_ddata;
    logic [3:0]  nb_dtag;

    logic [31:0] md [32];
    logic [3:0]  mt [32];
    logic [63:0] sb [$];

    int nchk;
    int nfail;
    int beats;
    int cycles;

    regfile_mp u_dut (
        .clk_i        (clk),
        .reset_n      (rst_n),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_tag_o     (rd_tag),
        .wa_en_i      (wa_en),
        .wa_addr_i    (wa_addr),
        .wa_data_i    (wa_data),
        .wa_tag_i     (wa_tag),
        .wb_en_i      (wb_en),
        .wb_addr_i    (wb_addr),
        .wb_data_i    (wb_data),
        .wb_tag_i     (wb_tag),
        .dump_start_i (start),
        .dump_busy_o  (busy),
        .dump_valid_o (valid),
        .dump_ready_i (ready),
        .dump_addr_o  (daddr),
        .dump_data_o  (ddata),
        .dump_tag_o   (dtag)
    );

    regfile_mp #(.BYPASS(0)) u_nb (
        .clk_i        (clk),
        .reset_n      (rst_n),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (nb_rd_data),
        .rd_tag_o     (nb_rd_tag),
        .wa_en_i      (wa_en),
        .wa_addr_i    (wa_addr),
        .wa_data_i    (wa_data),
        .wa_tag_i     (wa_tag),
        .wb_en_i      (wb_en),
        .wb_addr_i    (wb_addr),
        .wb_data_i    (wb_data),
        .wb_tag_i     (wb_tag),
        .dump_start_i (start),
        .dump_busy_o  (nb_busy),
        .dump_valid_o (nb_valid),
        .dump_ready_i (ready),
        .dump_addr_o  (nb_daddr),
        .dump_data_o  (nb_ddata),
        .dump_tag_o   (nb_dtag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] v);
        sb.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] obs);
        logic [63:0] e;
        nchk++;
        if (sb.size() == 0) begin
            nfail++;
            $error("FAIL %s: observed %h, scoreboard empty", name, obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", name, obs, e);
        end
    endtask

    function automatic logic [63:0] rd_obs(input int k);
        return 64'({rd_data[k*32 +: 32], rd_tag[k*4 +: 4]});
    endfunction

    function automatic logic [63:0] nb_obs();
        return 64'({nb_rd_data[31:0], nb_rd_tag[3:0]});
    endfunction

    function automatic logic [63:0] ent(input logic [31:0] d,
                                        input logic [3:0] t);
        return 64'({d, t});
    endfunction

    function automatic logic [63:0] beat_obs();
        return 64'({valid, daddr, ddata, dtag});
    endfunction

    function automatic bit pat(input int c);
        return (c % 4 == 0) || (c % 4 == 3);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            md[i] = '0;
            mt[i] = '0;
        end
    endtask

    task automatic run_dump(input bit stall, input int stop_at,
                            output int nb, output int nc);
        int c;
        int eptr;
        c = 0;
        eptr = 0;
        nb = 0;
        tick();
        start = 1'b1;
        ready = 1'b0;
        tick();
        start = 1'b0;
        while (nb < stop_at && c < 400) begin
            ready   = stall ? pat(c) : 1'b1;
            start   = stall && (c == 5);
            wa_en   = stall && !ready;
            wa_addr = 5'(eptr);
            wa_data = 32'hA500_0000 | 32'(c);
            wa_tag  = 4'(c);
            if (wa_en && eptr != 0) begin
                md[eptr] = wa_data;
                mt[eptr] = wa_tag;
            end
            if (ready)
                push(64'({1'b1, 5'(eptr), md[eptr], mt[eptr]}));
            @(negedge clk);
            if (ready) begin
                check("dump_beat", beat_obs());
                eptr++;
                nb++;
            end
            tick();
            c++;
        end
        wa_en = 1'b0;
        start = 1'b0;
        nc = c;
        if (nb < stop_at) begin
            nchk++;
            nfail++;
            $error("FAIL dump_timeout: observed %0d beats, expected %0d",
                   nb, stop_at);
        end
    endtask

    task automatic finish_dump();
        push(64'(2'b01));
        @(negedge clk);
        check("dump_done", 64'({valid, busy}));
        tick();
        push(64'(0));
        @(negedge clk);
        check("dump_idle", 64'({valid, busy}));
        ready = 1'b0;
    endtask

    initial begin
        nchk    = 0;
        nfail   = 0;
        rst_n   = 1'b0;
        rd_addr = '0;
        wa_en   = 1'b0;
        wa_addr = '0;
        wa_data = '0;
        wa_tag  = '0;
        wb_en   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        wb_tag  = '0;
        start   = 1'b0;
        ready   = 1'b0;
        clear_model();

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        push(64'(0));
        @(negedge clk);
        check("reset_dump", 64'({busy, valid, daddr}));

        for (int a = 0; a < 32; a++) begin
            tick();
            rd_addr = {5'(a + 2), 5'(a + 1), 5'(a)};
            for (int k = 0; k < 3; k++)
                push(ent(md[(a + k) % 32], mt[(a + k) % 32]));
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                check("reset_rd", rd_obs(k));
        end

        tick();
        rd_addr = {5'd0, 5'd0, 5'd5};
        wa_en   = 1'b1;
        wa_addr = 5'd5;
        wa_data = 32'hDEAD_BEEF;
        wa_tag  = 4'd3;
        push(ent(32'hDEAD_BEEF, 4'd3));
        push(ent(32'h0, 4'd0));
        @(negedge clk);
        check("byp_rd", rd_obs(0));
        check("nobyp_rd", nb_obs());
        md[5] = 32'hDEAD_BEEF;
        mt[5] = 4'd3;
        tick();
        wa_en = 1'b0;
        push(ent(md[5], mt[5]));
        push(ent(md[5], mt[5]));
        @(negedge clk);
        check("byp_rd_next", rd_obs(0));
        check("nobyp_rd_next", nb_obs());

        tick();
        rd_addr = {5'd0, 5'd7, 5'd7};
        wa_en   = 1'b1;
        wa_addr = 5'd7;
        wa_data = 32'h11;
        wa_tag  = 4'd1;
        wb_en   = 1'b1;
        wb_addr = 5'd7;
        wb_data = 32'h22;
        wb_tag  = 4'd2;
        push(ent(32'h22, 4'd2));
        push(ent(32'h22, 4'd2));
        push(ent(32'h0, 4'd0));
        @(negedge clk);
        check("prio_byp0", rd_obs(0));
        check("prio_byp1", rd_obs(1));
        check("prio_r0", rd_obs(2));
        md[7] = 32'h22;
        mt[7] = 4'd2;
        tick();
        wa_en = 1'b0;
        wb_en = 1'b0;
        push(ent(md[7], mt[7]));
        push(ent(md[7], mt[7]));
        @(negedge clk);
        check("prio_arr", rd_obs(0));
        check("prio_arr_nb", nb_obs());

        tick();
        rd_addr = '0;
        wa_en   = 1'b1;
        wa_addr = 5'd0;
        wa_data = 32'hFF;
        wa_tag  = 4'hF;
        wb_en   = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'h1234;
        wb_tag  = 4'd5;
        push(ent(32'h0, 4'd0));
        @(negedge clk);
        check("zero_byp", rd_obs(0));
        tick();
        wa_en = 1'b0;
        wb_en = 1'b0;
        push(ent(32'h0, 4'd0));
        push(ent(32'h0, 4'd0));
        @(negedge clk);
        check("zero_arr", rd_obs(0));
        check("zero_arr_nb", nb_obs());

        for (int i = 1; i < 32; i++) begin
            tick();
            wa_en   = 1'b1;
            wa_addr = 5'(i);
            wa_data = 32'(i * 3);
            wa_tag  = 4'(i % 16);
            md[i]   = 32'(i * 3);
            mt[i]   = 4'(i % 16);
        end
        tick();
        wa_en = 1'b0;

        run_dump(1'b0, 32, beats, cycles);
        push(64'(32));
        check("dump_b2b_cycles", 64'(cycles));
        finish_dump();

        run_dump(1'b1, 32, beats, cycles);
        finish_dump();

        run_dump(1'b0, 10, beats, cycles);
        rst_n = 1'b0;
        #1;
        clear_model();
        push(64'(0));
        check("rst_mid_dump", 64'({valid, busy, daddr}));
        rd_addr = {5'd31, 5'd7, 5'd5};
        #1;
        for (int k = 0; k < 3; k++) begin
            push(ent(32'h0, 4'd0));
            check("rst_mid_rd", rd_obs(k));
        end
        tick();
        rst_n = 1'b1;
        ready = 1'b0;

        run_dump(1'b0, 32, beats, cycles);
        push(64'(32));
        check("redump_cycles", 64'(cycles));
        finish_dump();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
